// File: rtl/core_bus_pkg.sv
// Shared definitions for the core-side buses: arbiter state encoding, owner IDs
// and default widths, also used by the peripheral bus.
package core_bus_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 32;
  localparam int DEFAULT_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT_IF = 2'd1,
    GRANT_D  = 2'd2
  } arb_state_e;

  localparam logic OWNER_IF = 1'b0;
  localparam logic OWNER_D  = 1'b1;

  // A disabled watchdog (limit 0) still needs a legal one-bit counter.
  function automatic int wdogWidth(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/memory_arbiter_if.sv
// Bus bundle around the memory arbiter: fetch port, data port and memory port.
// slave is the arbiter's view; master is the core/memory side.
interface memory_arbiter_if #(
  parameter int ADDR_WIDTH = core_bus_pkg::DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = core_bus_pkg::DEFAULT_DATA_WIDTH
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic [DATA_WIDTH-1:0] if_rdata;
  logic                  if_ack;
  logic                  if_err;

  logic                  d_req;
  logic                  d_we;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic [STRB_WIDTH-1:0] d_wstrb;
  logic [DATA_WIDTH-1:0] d_rdata;
  logic                  d_ack;
  logic                  d_err;

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [STRB_WIDTH-1:0] mem_wstrb;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ack;

  logic                  grant_d;
  logic                  busy;

  modport slave (
    input  if_req, if_addr,
    input  d_req, d_we, d_addr, d_wdata, d_wstrb,
    input  mem_rdata, mem_ack,
    output if_rdata, if_ack, if_err,
    output d_rdata, d_ack, d_err,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output grant_d, busy
  );

  modport master (
    output if_req, if_addr,
    output d_req, d_we, d_addr, d_wdata, d_wstrb,
    output mem_rdata, mem_ack,
    input  if_rdata, if_ack, if_err,
    input  d_rdata, d_ack, d_err,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  grant_d, busy
  );

endinterface

// File: rtl/bus_watchdog.sv
// Cycle counter that flags an access which has waited TIMEOUT_CYCLES without
// completing. A limit of 0 disables it.
module bus_watchdog
  import core_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int   CW      = wdogWidth(TIMEOUT_CYCLES);
  localparam logic ENABLED = (TIMEOUT_CYCLES != 0);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign expired = ENABLED && (count_q == CW'(TIMEOUT_CYCLES));

  // Saturates at the limit, so the counter can never wrap back to zero.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (run && ENABLED && !expired) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Shares one memory port between instruction fetch and data access, one
// transaction at a time, with round-robin or fixed priority and a timeout.
module memory_arbiter
  import core_bus_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int FIXED_PRIORITY = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             reset,
  memory_arbiter_if.slave  bus
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  arb_state_e            state_q;
  logic                  lastGrant_q;
  logic                  grantD_q;
  logic                  memReq_q;
  logic                  memWe_q;
  logic [ADDR_WIDTH-1:0] memAddr_q;
  logic [DATA_WIDTH-1:0] memWdata_q;
  logic [STRB_WIDTH-1:0] memWstrb_q;

  logic pickD;
  logic ifOwner;
  logic dOwner;
  logic wdogExpired;
  logic finish;

  assign pickD = bus.d_req && (!bus.if_req || (FIXED_PRIORITY != 0) || (lastGrant_q == OWNER_IF));

  assign ifOwner = (state_q == GRANT_IF);
  assign dOwner  = (state_q == GRANT_D);
  assign finish  = bus.mem_ack || wdogExpired;

  bus_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (state_q == IDLE),
    .run     ((state_q != IDLE) && !bus.mem_ack),
    .expired (wdogExpired)
  );

  // A real mem_ack beats a simultaneous expiry, so err only flags a true timeout.
  assign bus.if_ack   = ifOwner && finish;
  assign bus.if_err   = ifOwner && wdogExpired && !bus.mem_ack;
  assign bus.if_rdata = (ifOwner && bus.mem_ack) ? bus.mem_rdata : '0;
  assign bus.d_ack    = dOwner && finish;
  assign bus.d_err    = dOwner && wdogExpired && !bus.mem_ack;
  assign bus.d_rdata  = (dOwner && bus.mem_ack) ? bus.mem_rdata : '0;

  assign bus.mem_req   = memReq_q;
  assign bus.mem_we    = memWe_q;
  assign bus.mem_addr  = memAddr_q;
  assign bus.mem_wdata = memWdata_q;
  assign bus.mem_wstrb = memWstrb_q;
  assign bus.grant_d   = grantD_q;
  assign bus.busy      = (state_q != IDLE);

  // Command is captured at grant time and held untouched until completion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      lastGrant_q <= OWNER_D;
      grantD_q    <= OWNER_IF;
      memReq_q    <= 1'b0;
      memWe_q     <= 1'b0;
      memAddr_q   <= '0;
      memWdata_q  <= '0;
      memWstrb_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.if_req || bus.d_req) begin
            memReq_q    <= 1'b1;
            lastGrant_q <= pickD;
            grantD_q    <= pickD;
            if (pickD) begin
              state_q    <= GRANT_D;
              memWe_q    <= bus.d_we;
              memAddr_q  <= bus.d_addr;
              memWdata_q <= bus.d_wdata;
              memWstrb_q <= bus.d_wstrb;
            end else begin
              state_q    <= GRANT_IF;
              memWe_q    <= 1'b0;
              memAddr_q  <= bus.if_addr;
              memWdata_q <= '0;
              memWstrb_q <= '0;
            end
          end
        end
        GRANT_IF, GRANT_D: begin
          if (finish) begin
            state_q  <= IDLE;
            memReq_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= IDLE;
          memReq_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Shares one memory port between two requesters of the RV32 core: instruction fetch (IF) and data load/store (D).
- Sits between the core and a single unified memory; used when the design moves from split instruction/data memories to a shared memory with variable latency.
- One transaction is outstanding at a time. The block provides round-robin or fixed-priority arbitration and a watchdog timeout that returns an error ack.

Parameters:
- ADDR_WIDTH, 32, address width of all ports.
- DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8.
- FIXED_PRIORITY, 0: 0 = round-robin; 1 = D always wins a tie.
- TIMEOUT_CYCLES, 255: maximum cycles to wait for mem_ack before an error completion; 0 disables the timeout.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held with if_addr stable until if_ack.
- if_addr  in  ADDR_WIDTH  fetch address.
- if_rdata  out  DATA_WIDTH  fetch data; valid while if_ack=1.
- if_ack  out  1  one-cycle completion pulse for the fetch.
- if_err  out  1  fetch timed out; qualified by if_ack.
- d_req  in  1  data request; held with all d_* inputs stable until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_WIDTH  data address.
- d_wdata  in  DATA_WIDTH  store data.
- d_wstrb  in  DATA_WIDTH/8  byte enables for a store.
- d_rdata  out  DATA_WIDTH  load data; valid while d_ack=1.
- d_ack  out  1  one-cycle completion pulse for the data access.
- d_err  out  1  data access timed out; qualified by d_ack.
- mem_req  out  1  request to memory; held high until mem_ack.
- mem_we, mem_addr, mem_wdata, mem_wstrb  out  1/ADDR/DATA/DATA/8  registered memory command.
- mem_rdata  in  DATA_WIDTH  memory read data; valid with mem_ack.
- mem_ack  in  1  memory completion pulse.
- grant_d  out  1  current owner: 0 = IF, 1 = D; held when idle.
- busy  out  1  a transaction is in flight (state != IDLE).

Behaviour:
- States: IDLE, GRANT_IF, GRANT_D (encoding from shared package).
- Reset (reset=0, asynchronous):
  - state = IDLE; all mem_* outputs = 0.
  - last_grant = D, so IF wins the first tie after boot.
  - grant_d = 0; busy = 0; watchdog counter = 0.
  - All ack and err outputs = 0; if_rdata and d_rdata = 0.
- Arbitration in IDLE:
  - Exactly one req → grant it.
  - Both req and FIXED_PRIORITY=1 → D wins.
  - Both req and FIXED_PRIORITY=0 → the requester other than last_grant wins.
  - On a grant: register the winner's command onto mem_*, set mem_req=1, update last_grant and grant_d, clear the watchdog. mem_req rises one cycle after req is first seen in IDLE.
  - IF grants always drive mem_we=0 and mem_wstrb=0.
- GRANT_x:
  - mem_* held constant.
  - On mem_ack: x_ack=1 and x_rdata=mem_rdata combinationally in the same cycle; other requester's ack=0. Next edge: mem_req=0, state = IDLE.
  - Requester must deassert or replace its req in the cycle after ack. Req seen in IDLE is always a new request.
- Back-to-back throughput: at most one transaction per (memory latency + 1) cycles. Minimum is 2 cycles per access with a 1-cycle memory.
- Watchdog (TIMEOUT_CYCLES>0):
  - Counter increments each cycle in GRANT_x without mem_ack.
  - When it reaches TIMEOUT_CYCLES: x_ack=1, x_err=1, x_rdata=0 for one cycle; mem_req dropped; state → IDLE.
  - A mem_ack in the same cycle as expiry takes precedence: normal completion, err=0.
- Boundary conditions:
  - mem_ack while IDLE: ignored; no ack, no state change.
  - Requester drops req mid-transaction: illegal, but the arbiter still completes and pulses ack.
  - Reset mid-transaction: mem_req drops asynchronously; the pending access is abandoned and no ack is issued.
  - Late mem_ack after a timeout, arriving in IDLE: ignored, as above.
  - Counter width is clog2(TIMEOUT_CYCLES+1); no wrap is possible before expiry.

Decomposition:
- Shared package (core_bus_pkg):
  - State enum constants IDLE=2'd0, GRANT_IF=2'd1, GRANT_D=2'd2.
  - Owner IDs OWNER_IF=1'b0, OWNER_D=1'b1.
  - Default widths.
- One sub-module: bus_watchdog (parameter TIMEOUT_CYCLES; inputs clk, reset, clear, run; output expired). Reused later by the peripheral bus.

Test Plan:
- Single fetch: if_req=1, if_addr=32'h0000_0010; memory acks 3 cycles after mem_req with 32'h0050_0093 → mem_addr=32'h10 and mem_we=0; if_ack a single pulse with if_rdata=32'h0050_0093; busy falls the next cycle.
- Tie, round-robin: if_req and d_req both held high from reset, memory 1-cycle → grant order IF, D, IF, D; each requester acked every 4 cycles.
- Tie, FIXED_PRIORITY=1: both req continuously → only d_ack pulses; IF starves, as specified.
- Store path: d_req=1, d_we=1, d_addr=32'h0000_0100, d_wdata=32'hDEAD_BEEF, d_wstrb=4'b0011 → mem_* carries identical values; d_ack when mem_ack arrives; if_ack stays 0.
- Timeout, TIMEOUT_CYCLES=8: memory never acks → d_ack=1 and d_err=1 exactly 8 cycles after mem_req rose, d_rdata=0, state IDLE. A late mem_ack 3 cycles later produces no ack.
- Reset mid-transaction: assert reset=0 two cycles after mem_req rises → mem_req=0 immediately, without waiting for a clock edge; no ack. After release with if_req high, IF is granted first.
